mult_result_fifo: RTL and testbench

Result buffer that sits directly downstream of the sequential Booth multiplier, consuming its product over a valid/ready handshake. It holds up to DEPTH products so the multiplier can finish and return to accepting operands while the sink is stalled. Results are presented to the sink in first-in, first-out order over a second valid/ready handshake.

---
 rtl/mult_result_fifo.sv | 86 ++++++++
 tb/tb_mult_result_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_fifo.sv
// FIFO buffering Booth multiplier products toward a possibly stalled sink.
// Optional zero-latency bypass when empty: define MULT_RESULT_FIFO_BYPASS_EN.
module mult_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     src_valid,
  input  logic [DATA_W-1:0]        src_data,
  output logic                     src_ready,
  output logic                     dest_valid,
  output logic [DATA_W-1:0]        dest_data,
  input  logic                     dest_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              push;
  logic              pop;
  logic              full_int;
  logic              empty_int;

  // Status comes only from registered count, never from the handshake inputs.
  assign full_int  = (count_reg == CNT_W'(DEPTH));
  assign empty_int = (count_reg == '0);
  assign full      = full_int;
  assign empty     = empty_int;
  assign count     = count_reg;
  assign src_ready = !full_int;

`ifdef MULT_RESULT_FIFO_BYPASS_EN
  logic bypass_hit;
  // An arriving product on an empty buffer is shown to the sink immediately;
  // it is only stored if the sink does not take it this cycle.
  assign bypass_hit = empty_int & src_valid;
  assign dest_valid = !empty_int | src_valid;
  assign dest_data  = bypass_hit ? src_data : mem[rd_ptr_reg];
  assign push       = src_valid & !full_int & !(bypass_hit & dest_ready);
  assign pop        = !empty_int & dest_ready;
`else
  assign dest_valid = !empty_int;
  assign dest_data  = mem[rd_ptr_reg];
  assign push       = src_valid & !full_int;
  assign pop        = !empty_int & dest_ready;
`endif

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_reg] <= src_data;
  end

endmodule

// File: tb/tb_mult_result_fifo.sv
// Directed self-checking bench for mult_result_fifo (DEPTH=4, DATA_W=32).
// Expected values are hand-computed constants and a small in-order list.
module tb_mult_result_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              dest_valid;
  logic [DATA_W-1:0] dest_data;
  logic              dest_ready;
  logic [2:0]        count;
  logic              full;
  logic              empty;

  int n_cmp = 0;
  int n_err = 0;

  mult_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .dest_valid (dest_valid),
    .dest_data  (dest_data),
    .dest_ready (dest_ready),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] d);
    src_valid = 1'b1;
    src_data  = d;
    tick();
    src_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] d);
    dest_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid"}, 32'(dest_valid), 32'd1);
    chk({tag, "_data"}, dest_data, d);
    tick();
    dest_ready = 1'b0;
  endtask

  logic [31:0] prod [6];
  logic [31:0] got_q [$];
  int          n_sent;

  initial begin
    rst = 1'b1; src_valid = 1'b0; src_data = '0; dest_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dvalid", 32'(dest_valid), 32'd0);
    chk("rst_sready", 32'(src_ready), 32'd1);
    tick();

    // Basic ordering
    for (int i = 1; i <= 3; i++) push_one(32'(i));
    @(negedge clk);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_full", 32'(full), 32'd0);
    tick();
    for (int i = 1; i <= 3; i++) pop_expect("t1_pop", 32'(i));
    @(negedge clk);
    chk("t1_empty", 32'(empty), 32'd1);
    tick();

    // Full and backpressure
    for (int i = 0; i < 4; i++) push_one(32'hA0 + 32'(i));
    src_valid = 1'b1; src_data = 32'hA4;
    @(negedge clk);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_sready", 32'(src_ready), 32'd0);
    tick();
    dest_ready = 1'b1;
    @(negedge clk);
    chk("t2_pop_data", dest_data, 32'hA0);
    chk("t2_sready_pop", 32'(src_ready), 32'd0);
    tick();
    dest_ready = 1'b0;
    @(negedge clk);
    chk("t2_count_after_pop", 32'(count), 32'd3);
    chk("t2_sready_back", 32'(src_ready), 32'd1);
    tick();
    src_valid = 1'b0;
    @(negedge clk);
    chk("t2_count_a4", 32'(count), 32'd4);
    tick();
    for (int i = 1; i <= 4; i++) pop_expect("t2_drain", 32'hA0 + 32'(i));

    // Sustained push+pop at count=2 across wrap
    push_one(32'h10);
    push_one(32'h11);
    for (int k = 0; k < 10; k++) begin
      src_valid = 1'b1; src_data = 32'h12 + 32'(k); dest_ready = 1'b1;
      @(negedge clk);
      chk("t3_data", dest_data, 32'h10 + 32'(k));
      chk("t3_count", 32'(count), 32'd2);
      tick();
    end
    src_valid = 1'b0; dest_ready = 1'b0;
    pop_expect("t3_tail", 32'h1A);
    pop_expect("t3_tail", 32'h1B);

    // Reset mid-operation, with a product offered in the reset cycle
    push_one(32'h55);
    push_one(32'h66);
    push_one(32'h77);
    rst = 1'b1; src_valid = 1'b1; src_data = 32'h99;
    tick();
    rst = 1'b0; src_valid = 1'b0;
    @(negedge clk);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_dvalid", 32'(dest_valid), 32'd0);
    tick();
    push_one(32'h0000BEEF);
    pop_expect("t4_fresh", 32'h0000BEEF);
    @(negedge clk);
    chk("t4_empty_end", 32'(empty), 32'd1);
    tick();

    // 7 * -3 = -21 from the multiplier, sink always ready
    src_valid = 1'b1; src_data = 32'hFFFF_FFEB; dest_ready = 1'b1;
    @(negedge clk);
`ifdef MULT_RESULT_FIFO_BYPASS_EN
    chk("t5_byp_valid", 32'(dest_valid), 32'd1);
    chk("t5_byp_data", dest_data, 32'hFFFF_FFEB);
    tick();
    src_valid = 1'b0;
    @(negedge clk);
    chk("t5_byp_count", 32'(count), 32'd0);
    chk("t5_byp_dvalid", 32'(dest_valid), 32'd0);
    tick();
`else
    chk("t5_accept_dvalid", 32'(dest_valid), 32'd0);
    tick();
    src_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(dest_valid), 32'd1);
    chk("t5_data", dest_data, 32'hFFFF_FFEB);
    tick();
    @(negedge clk);
    chk("t5_empty", 32'(empty), 32'd1);
    tick();
`endif
    dest_ready = 1'b0;

    // Sink stalled 20 cycles while 6 products arrive, then released
    prod[0] = 32'h0000_0006; prod[1] = 32'hFFFF_FFF1; prod[2] = 32'h0000_0C00;
    prod[3] = 32'h7FFF_0001; prod[4] = 32'h8000_0000; prod[5] = 32'h0000_0123;
    n_sent = 0;
    got_q.delete();
    for (int c = 0; c < 60 && got_q.size() < 6; c++) begin
      dest_ready = (c >= 20);
      src_valid  = (n_sent < 6);
      src_data   = (n_sent < 6) ? prod[n_sent] : 32'h0;
      @(negedge clk);
      if (c == 19) begin
        chk("t6_stall_count", 32'(count), 32'd4);
        chk("t6_stall_full", 32'(full), 32'd1);
        chk("t6_held_in_wait", 32'(n_sent), 32'd4);
      end
      if (dest_valid && dest_ready) got_q.push_back(dest_data);
      if (src_valid && src_ready) n_sent++;
      tick();
    end
    src_valid = 1'b0; dest_ready = 1'b0;
    chk("t6_delivered", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) chk("t6_order", got_q[i], prod[i]);
    @(negedge clk);
    chk("t6_empty_end", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
